// File: rtl/game_flow_ctrl.sv
// Multi-level tilt-maze game sequencer: lives, level progression, fail-hole masking and layout handshake.
// Define GAME_TIMER_EN to build the per-attempt frame timer and timeout-fail path.
module game_flow_ctrl #(
    parameter int unsigned MAX_FAILHOLE_NUM  = 7,
    parameter int unsigned COORD_BIT         = 10,
    parameter int unsigned MAX_LIVES         = 3,
    parameter int unsigned NUM_LEVELS        = 4,
    parameter int unsigned BASE_HOLES        = 3,
    parameter int unsigned HOLES_PER_LEVEL   = 2,
    parameter int unsigned TIME_LIMIT_FRAMES = 1800,
    parameter int unsigned BL_INIT_X         = 144,
    parameter int unsigned BL_INIT_Y         = 74
) (
    input  logic                                          CLK,
    input  logic                                          rst,
    input  logic                                          i_new_game,
    input  logic                                          i_again,
    input  logic                                          i_rand_ready,
    input  logic [2*COORD_BIT*(MAX_FAILHOLE_NUM+2)-1:0]   i_rand_list,
    input  logic                                          i_accel_ready,
    input  logic                                          i_screenend,
    input  logic                                          i_win,
    input  logic                                          i_fail,
    input  logic [COORD_BIT-1:0]                          i_rolling_x,
    input  logic [COORD_BIT-1:0]                          i_rolling_y,
    input  logic [COORD_BIT-1:0]                          i_fix_x,
    input  logic [COORD_BIT-1:0]                          i_fix_y,
    output logic [COORD_BIT-1:0]                          o_bl_x,
    output logic [COORD_BIT-1:0]                          o_bl_y,
    output logic [COORD_BIT-1:0]                          o_bl_pos_initial_x,
    output logic [COORD_BIT-1:0]                          o_bl_pos_initial_y,
    output logic [COORD_BIT-1:0]                          o_wh_pos_x,
    output logic [COORD_BIT-1:0]                          o_wh_pos_y,
    output logic [COORD_BIT*MAX_FAILHOLE_NUM-1:0]         o_fh_pos_x,
    output logic [COORD_BIT*MAX_FAILHOLE_NUM-1:0]         o_fh_pos_y,
    output logic [MAX_FAILHOLE_NUM-1:0]                   o_fh_active,
    output logic                                          o_bl_pos_rst,
    output logic                                          o_is_game_playing,
    output logic                                          o_rand_req,
    output logic [3:0]                                    o_state,
    output logic [3:0]                                    o_lives,
    output logic [3:0]                                    o_level,
    output logic [11:0]                                   o_time_left,
    output logic                                          o_game_over
);

    localparam int unsigned N     = MAX_FAILHOLE_NUM;
    localparam int unsigned C     = COORD_BIT;
    localparam int unsigned FH_W  = N * C;
    localparam int unsigned Y_OFS = (N + 2) * C;

    typedef enum logic [3:0] {
        S_PLAYING  = 4'h1,
        S_FAIL     = 4'h2,
        S_WIN      = 4'h3,
        S_NEW      = 4'h4,
        S_AGAIN    = 4'h5,
        S_BALL_RST = 4'h6,
        S_NEXT     = 4'h7,
        S_OVER     = 4'h8,
        S_CLEAR    = 4'h9
    } state_t;

    state_t state;
    state_t state_next;
    logic   rand_prev;
    logic   rand_rise;
    logic   last_level;
    logic   timeout;

    // Active fail holes: lowest min(N, BASE_HOLES + lvl*HOLES_PER_LEVEL) bits set.
    function automatic logic [MAX_FAILHOLE_NUM-1:0] fh_mask(input logic [3:0] lvl);
        int unsigned cnt;
        fh_mask = '0;
        cnt     = BASE_HOLES + HOLES_PER_LEVEL * 32'(lvl);
        for (int unsigned k = 0; k < N; k++) begin
            if (k < cnt) fh_mask = (fh_mask << 1) | N'(1);
        end
    endfunction

    assign rand_rise  = i_rand_ready & ~rand_prev;
    assign last_level = (o_level == 4'(NUM_LEVELS - 1));
    assign o_state    = state;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= S_NEW;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (i_new_game) begin
            state_next = S_NEW;
        end else begin
            case (state)
                S_NEW:      if (i_rand_ready && i_accel_ready) state_next = S_BALL_RST;
                S_BALL_RST: state_next = S_PLAYING;
                S_AGAIN:    state_next = S_PLAYING;
                S_PLAYING: begin
                    if (i_again)                 state_next = S_AGAIN;
                    else if (i_fail || timeout)  state_next = S_FAIL;
                    else if (i_win)              state_next = S_WIN;
                end
                // lives already reflects the decrement taken on entry to FAIL
                S_FAIL: begin
                    if (o_lives == 4'd0) state_next = S_OVER;
                    else if (i_again)    state_next = S_AGAIN;
                end
                S_WIN:      if (i_again) state_next = last_level ? S_CLEAR : S_NEXT;
                S_NEXT:     if (rand_rise) state_next = S_BALL_RST;
                S_OVER:     state_next = S_OVER;
                S_CLEAR:    state_next = S_CLEAR;
                default:    state_next = S_NEW;
            endcase
        end
    end

    // Game progress, status strobes and layout registers.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rand_prev          <= 1'b0;
            o_lives            <= 4'(MAX_LIVES);
            o_level            <= 4'd0;
            o_fh_active        <= fh_mask(4'd0);
            o_rand_req         <= 1'b0;
            o_bl_pos_rst       <= 1'b0;
            o_is_game_playing  <= 1'b0;
            o_game_over        <= 1'b0;
            o_fh_pos_x         <= '0;
            o_fh_pos_y         <= '0;
            o_wh_pos_x         <= '0;
            o_wh_pos_y         <= '0;
            o_bl_pos_initial_x <= C'(BL_INIT_X);
            o_bl_pos_initial_y <= C'(BL_INIT_Y);
        end else begin
            rand_prev         <= i_rand_ready;
            o_rand_req        <= (state == S_WIN) && (state_next == S_NEXT);
            o_bl_pos_rst      <= (state_next == S_BALL_RST) || (state_next == S_AGAIN);
            o_is_game_playing <= (state_next == S_PLAYING);
            o_game_over       <= (state_next == S_OVER) || (state_next == S_CLEAR);

            if (i_new_game) begin
                o_lives     <= 4'(MAX_LIVES);
                o_level     <= 4'd0;
                o_fh_active <= fh_mask(4'd0);
            end else begin
                if ((state == S_PLAYING) && (state_next == S_FAIL) && (o_lives != 4'd0))
                    o_lives <= o_lives - 4'd1;
                if ((state == S_WIN) && (state_next == S_NEXT)) begin
                    o_level     <= o_level + 4'd1;
                    o_fh_active <= fh_mask(o_level + 4'd1);
                end
            end

            if (((state == S_NEW) || (state == S_NEXT)) && (state_next == S_BALL_RST)) begin
                o_fh_pos_x         <= i_rand_list[0 +: FH_W];
                o_wh_pos_x         <= i_rand_list[FH_W +: C];
                o_bl_pos_initial_x <= i_rand_list[FH_W + C +: C];
                o_fh_pos_y         <= i_rand_list[Y_OFS +: FH_W];
                o_wh_pos_y         <= i_rand_list[Y_OFS + FH_W +: C];
                o_bl_pos_initial_y <= i_rand_list[Y_OFS + FH_W + C +: C];
            end
        end
    end

`ifdef GAME_TIMER_EN
    logic [11:0] time_left;

    // Reloaded while the ball is being reset, counts frames down while playing.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            time_left <= 12'(TIME_LIMIT_FRAMES);
        end else if ((state == S_BALL_RST) || (state == S_AGAIN)) begin
            time_left <= 12'(TIME_LIMIT_FRAMES);
        end else if ((state == S_PLAYING) && i_screenend && (time_left != 12'd0)) begin
            time_left <= time_left - 12'd1;
        end
    end

    assign timeout     = (time_left == 12'd0);
    assign o_time_left = time_left;
`else
    logic screenend_unused;

    assign screenend_unused = i_screenend;
    assign timeout          = 1'b0;
    assign o_time_left      = 12'(TIME_LIMIT_FRAMES);
`endif

    // Displayed ball follows the motion source that owns the current state.
    always_comb begin
        o_bl_x = o_bl_pos_initial_x;
        o_bl_y = o_bl_pos_initial_y;
        case (state)
            S_PLAYING: begin
                o_bl_x = i_rolling_x;
                o_bl_y = i_rolling_y;
            end
            S_FAIL, S_WIN, S_OVER, S_CLEAR: begin
                o_bl_x = i_fix_x;
                o_bl_y = i_fix_y;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed vector table, corner sequences and a random run
// checked against a rule-level reference model.
module tb_game_flow_ctrl;

    localparam int N    = 7;
    localparam int C    = 10;
    localparam int MAXL = 3;
    localparam int NL   = 4;
    localparam int BH   = 3;
    localparam int HPL  = 2;
    localparam int TL   = 3;
    localparam int BIX  = 144;
    localparam int BIY  = 74;
    localparam int LW   = 2 * C * (N + 2);

    localparam int ST_PLAY = 1, ST_FAIL = 2, ST_WIN = 3, ST_NEW = 4, ST_AGAIN = 5;
    localparam int ST_BRST = 6, ST_NEXT = 7, ST_OVER = 8, ST_CLEAR = 9;

`ifdef GAME_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              rst;
    logic              i_new_game, i_again, i_rand_ready, i_accel_ready, i_screenend, i_win, i_fail;
    logic [LW-1:0]     i_rand_list;
    logic [C-1:0]      i_rolling_x, i_rolling_y, i_fix_x, i_fix_y;
    logic [C-1:0]      o_bl_x, o_bl_y, o_bl_pos_initial_x, o_bl_pos_initial_y, o_wh_pos_x, o_wh_pos_y;
    logic [C*N-1:0]    o_fh_pos_x, o_fh_pos_y;
    logic [N-1:0]      o_fh_active;
    logic              o_bl_pos_rst, o_is_game_playing, o_rand_req, o_game_over;
    logic [3:0]        o_state, o_lives, o_level;
    logic [11:0]       o_time_left;

    game_flow_ctrl #(
        .MAX_FAILHOLE_NUM(N), .COORD_BIT(C), .MAX_LIVES(MAXL), .NUM_LEVELS(NL),
        .BASE_HOLES(BH), .HOLES_PER_LEVEL(HPL), .TIME_LIMIT_FRAMES(TL),
        .BL_INIT_X(BIX), .BL_INIT_Y(BIY)
    ) dut (
        .CLK(CLK), .rst(rst), .i_new_game(i_new_game), .i_again(i_again),
        .i_rand_ready(i_rand_ready), .i_rand_list(i_rand_list), .i_accel_ready(i_accel_ready),
        .i_screenend(i_screenend), .i_win(i_win), .i_fail(i_fail),
        .i_rolling_x(i_rolling_x), .i_rolling_y(i_rolling_y), .i_fix_x(i_fix_x), .i_fix_y(i_fix_y),
        .o_bl_x(o_bl_x), .o_bl_y(o_bl_y),
        .o_bl_pos_initial_x(o_bl_pos_initial_x), .o_bl_pos_initial_y(o_bl_pos_initial_y),
        .o_wh_pos_x(o_wh_pos_x), .o_wh_pos_y(o_wh_pos_y),
        .o_fh_pos_x(o_fh_pos_x), .o_fh_pos_y(o_fh_pos_y), .o_fh_active(o_fh_active),
        .o_bl_pos_rst(o_bl_pos_rst), .o_is_game_playing(o_is_game_playing), .o_rand_req(o_rand_req),
        .o_state(o_state), .o_lives(o_lives), .o_level(o_level), .o_time_left(o_time_left),
        .o_game_over(o_game_over)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Layout currently offered on i_rand_list, kept as separate fields.
    int lay_fhx[N], lay_fhy[N];
    int lay_whx, lay_why, lay_bx, lay_by;

    // Reference model state.
    int m_st, m_lives, m_lvl, m_time, m_prev;
    int m_bix, m_biy, m_whx, m_why;
    int m_fhx[N], m_fhy[N];
    int m_req;

    typedef struct {
        logic ng, ag, rr, ar, w, f;
        int   lay, e_st, e_lives, e_lvl, e_req, e_brst;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mkv(input logic ng, ag, rr, ar, w, f,
                                 input int lay, st, lv, lvl, rq, br);
        vec_t v;
        v.ng = ng; v.ag = ag; v.rr = rr; v.ar = ar; v.w = w; v.f = f;
        v.lay = lay; v.e_st = st; v.e_lives = lv; v.e_lvl = lvl; v.e_req = rq; v.e_brst = br;
        return v;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [N-1:0] exp_mask(input int lvl);
        int m;
        logic [63:0] one = 64'd1;
        m = BH + lvl * HPL;
        if (m > N) m = N;
        return N'((one << m) - one);
    endfunction

    function automatic logic [LW-1:0] pack_list();
        logic [LW-1:0] v = '0;
        for (int k = 0; k < N; k++) begin
            v[k*C +: C]             = C'(lay_fhx[k]);
            v[(N+2)*C + k*C +: C]   = C'(lay_fhy[k]);
        end
        v[N*C +: C]               = C'(lay_whx);
        v[(N+1)*C +: C]           = C'(lay_bx);
        v[(N+2)*C + N*C +: C]     = C'(lay_why);
        v[(N+2)*C + (N+1)*C +: C] = C'(lay_by);
        return v;
    endfunction

    task automatic use_layout(input int id);
        for (int k = 0; k < N; k++) begin
            lay_fhx[k] = 100 * id + 10 + k;
            lay_fhy[k] = 100 * id + 30 + k;
        end
        lay_whx = 100 * id + 5;
        lay_why = 100 * id + 7;
        lay_bx  = (id == 0) ? 50 : 77;
        lay_by  = (id == 0) ? 60 : 88;
        i_rand_list = pack_list();
    endtask

    task automatic rand_layout();
        for (int k = 0; k < N; k++) begin
            lay_fhx[k] = int'($urandom_range(0, 1023));
            lay_fhy[k] = int'($urandom_range(0, 1023));
        end
        lay_whx = int'($urandom_range(0, 1023));
        lay_why = int'($urandom_range(0, 1023));
        lay_bx  = int'($urandom_range(0, 1023));
        lay_by  = int'($urandom_range(0, 1023));
        i_rand_list = pack_list();
    endtask

    task automatic set_in(input logic ng, ag, rr, ar, se, w, f);
        i_new_game = ng; i_again = ag; i_rand_ready = rr; i_accel_ready = ar;
        i_screenend = se; i_win = w; i_fail = f;
    endtask

    task automatic model_reset();
        m_st = ST_NEW; m_lives = MAXL; m_lvl = 0; m_time = TL; m_prev = 0; m_req = 0;
        m_bix = BIX; m_biy = BIY; m_whx = 0; m_why = 0;
        for (int k = 0; k < N; k++) begin
            m_fhx[k] = 0;
            m_fhy[k] = 0;
        end
    endtask

    // One clock edge of the game rules applied to the inputs now being driven.
    task automatic model_step();
        int nx;
        nx = m_st;
        if (i_new_game) nx = ST_NEW;
        else if (m_st == ST_NEW && i_rand_ready && i_accel_ready) nx = ST_BRST;
        else if (m_st == ST_BRST || m_st == ST_AGAIN) nx = ST_PLAY;
        else if (m_st == ST_PLAY) begin
            if (i_again) nx = ST_AGAIN;
            else if (i_fail || (TIMER_ON && m_time == 0)) nx = ST_FAIL;
            else if (i_win) nx = ST_WIN;
        end
        else if (m_st == ST_FAIL) begin
            if (m_lives == 0) nx = ST_OVER;
            else if (i_again) nx = ST_AGAIN;
        end
        else if (m_st == ST_WIN && i_again) nx = (m_lvl < NL - 1) ? ST_NEXT : ST_CLEAR;
        else if (m_st == ST_NEXT && i_rand_ready && m_prev == 0) nx = ST_BRST;

        m_req = (m_st == ST_WIN && nx == ST_NEXT) ? 1 : 0;
        if (i_new_game) begin
            m_lives = MAXL;
            m_lvl   = 0;
        end else begin
            if (m_st == ST_PLAY && nx == ST_FAIL) m_lives = m_lives - 1;
            if (m_st == ST_WIN && nx == ST_NEXT) m_lvl = m_lvl + 1;
        end
        if ((m_st == ST_NEW || m_st == ST_NEXT) && nx == ST_BRST) begin
            m_bix = lay_bx; m_biy = lay_by; m_whx = lay_whx; m_why = lay_why;
            for (int k = 0; k < N; k++) begin
                m_fhx[k] = lay_fhx[k];
                m_fhy[k] = lay_fhy[k];
            end
        end
        if (TIMER_ON) begin
            if (m_st == ST_BRST || m_st == ST_AGAIN) m_time = TL;
            else if (m_st == ST_PLAY && i_screenend && m_time > 0) m_time = m_time - 1;
        end
        m_prev = i_rand_ready ? 1 : 0;
        m_st   = nx;
    endtask

    task automatic check_all();
        int ex, ey;
        chk("state", 64'(o_state), 64'(m_st));
        chk("lives", 64'(o_lives), 64'(m_lives));
        chk("level", 64'(o_level), 64'(m_lvl));
        chk("time_left", 64'(o_time_left), 64'(m_time));
        chk("fh_active", 64'(o_fh_active), 64'(exp_mask(m_lvl)));
        chk("rand_req", 64'(o_rand_req), 64'(m_req));
        chk("bl_pos_rst", 64'(o_bl_pos_rst), 64'(m_st == ST_BRST || m_st == ST_AGAIN));
        chk("playing", 64'(o_is_game_playing), 64'(m_st == ST_PLAY));
        chk("game_over", 64'(o_game_over), 64'(m_st == ST_OVER || m_st == ST_CLEAR));
        chk("init_x", 64'(o_bl_pos_initial_x), 64'(m_bix));
        chk("init_y", 64'(o_bl_pos_initial_y), 64'(m_biy));
        chk("wh_x", 64'(o_wh_pos_x), 64'(m_whx));
        chk("wh_y", 64'(o_wh_pos_y), 64'(m_why));
        for (int k = 0; k < N; k++) begin
            chk("fh_x", 64'(o_fh_pos_x[k*C +: C]), 64'(m_fhx[k]));
            chk("fh_y", 64'(o_fh_pos_y[k*C +: C]), 64'(m_fhy[k]));
        end
        if (m_st == ST_PLAY) begin
            ex = int'(i_rolling_x); ey = int'(i_rolling_y);
        end else if (m_st == ST_FAIL || m_st == ST_WIN || m_st == ST_OVER || m_st == ST_CLEAR) begin
            ex = int'(i_fix_x); ey = int'(i_fix_y);
        end else begin
            ex = m_bix; ey = m_biy;
        end
        chk("bl_x", 64'(o_bl_x), 64'(ex));
        chk("bl_y", 64'(o_bl_y), 64'(ey));
    endtask

    // Inputs are driven at a negedge; outputs are compared at the following negedge.
    task automatic cycle();
        model_step();
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        use_layout(0);
        i_rolling_x = 10'd300; i_rolling_y = 10'd301; i_fix_x = 10'd400; i_fix_y = 10'd401;
        model_reset();
        repeat (2) @(negedge CLK);

        chk("rst_state", 64'(o_state), 64'(ST_NEW));
        chk("rst_lives", 64'(o_lives), 64'(MAXL));
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_time", 64'(o_time_left), 64'(TL));
        chk("rst_fh_active", 64'(o_fh_active), 64'h07);
        chk("rst_init_x", 64'(o_bl_pos_initial_x), 64'(BIX));
        chk("rst_init_y", 64'(o_bl_pos_initial_y), 64'(BIY));
        chk("rst_strobes", 64'({o_rand_req, o_bl_pos_rst, o_game_over}), 64'd0);
        check_all();
        rst = 1'b0;

        tbl[0]  = mkv(0,0,1,1,0,0, 0, ST_BRST, 3, 0, 0, 1);
        tbl[1]  = mkv(0,0,1,1,0,0, 0, ST_PLAY, 3, 0, 0, 0);
        tbl[2]  = mkv(0,0,0,0,0,1, 0, ST_FAIL, 2, 0, 0, 0);
        tbl[3]  = mkv(0,1,0,0,0,0, 0, ST_AGAIN,2, 0, 0, 1);
        tbl[4]  = mkv(0,0,0,0,0,0, 0, ST_PLAY, 2, 0, 0, 0);
        tbl[5]  = mkv(0,0,0,0,1,1, 0, ST_FAIL, 1, 0, 0, 0);
        tbl[6]  = mkv(0,1,0,0,0,0, 0, ST_AGAIN,1, 0, 0, 1);
        tbl[7]  = mkv(0,1,0,0,0,0, 0, ST_PLAY, 1, 0, 0, 0);
        tbl[8]  = mkv(0,0,0,0,1,0, 0, ST_WIN,  1, 0, 0, 0);
        tbl[9]  = mkv(0,1,0,0,0,0, 0, ST_NEXT, 1, 1, 1, 0);
        tbl[10] = mkv(0,0,0,0,0,0, 0, ST_NEXT, 1, 1, 0, 0);
        tbl[11] = mkv(0,0,1,0,0,0, 1, ST_BRST, 1, 1, 0, 1);
        tbl[12] = mkv(0,0,1,0,0,0, 1, ST_PLAY, 1, 1, 0, 0);
        tbl[13] = mkv(0,0,0,0,0,1, 1, ST_FAIL, 0, 1, 0, 0);
        tbl[14] = mkv(0,0,0,0,0,0, 1, ST_OVER, 0, 1, 0, 0);
        tbl[15] = mkv(0,1,0,0,0,0, 1, ST_OVER, 0, 1, 0, 0);
        tbl[16] = mkv(1,0,0,0,0,0, 1, ST_NEW,  3, 0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].ng, tbl[i].ag, tbl[i].rr, tbl[i].ar, 1'b0, tbl[i].w, tbl[i].f);
            use_layout(tbl[i].lay);
            cycle();
            chk("tbl_state", 64'(o_state), 64'(tbl[i].e_st));
            chk("tbl_lives", 64'(o_lives), 64'(tbl[i].e_lives));
            chk("tbl_level", 64'(o_level), 64'(tbl[i].e_lvl));
            chk("tbl_rand_req", 64'(o_rand_req), 64'(tbl[i].e_req));
            chk("tbl_bl_pos_rst", 64'(o_bl_pos_rst), 64'(tbl[i].e_brst));
            chk("tbl_game_over", 64'(o_game_over), 64'(tbl[i].e_st >= ST_OVER));
            chk("tbl_fh_active", 64'(o_fh_active), 64'(exp_mask(tbl[i].e_lvl)));
            if (i == 0) chk("tbl_init_l0", 64'({o_bl_pos_initial_x, o_bl_pos_initial_y}), 64'({10'd50, 10'd60}));
            if (i == 11) chk("tbl_init_l1", 64'({o_bl_pos_initial_x, o_bl_pos_initial_y}), 64'({10'd77, 10'd88}));
        end

        // Frame timer: three end-of-frame pulses then a possible timeout.
        set_in(0, 0, 1, 1, 0, 0, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0); cycle();
        chk("tmr_play", 64'(o_state), 64'(ST_PLAY));
        for (int p = 1; p <= 3; p++) begin
            set_in(0, 0, 0, 0, 1, 0, 0); cycle();
            chk("tmr_count", 64'(o_time_left), TIMER_ON ? 64'(TL - p) : 64'(TL));
            set_in(0, 0, 0, 0, 0, 0, 0); cycle();
        end
        chk("tmr_state", 64'(o_state), TIMER_ON ? 64'(ST_FAIL) : 64'(ST_PLAY));
        chk("tmr_lives", 64'(o_lives), TIMER_ON ? 64'(MAXL - 1) : 64'(MAXL));

        // Walk every level to CLEAR, then restart.
        set_in(1, 0, 0, 0, 0, 0, 0); cycle();
        chk("clr_new", 64'(o_state), 64'(ST_NEW));
        set_in(0, 0, 1, 1, 0, 0, 0); cycle();
        for (int lv = 0; lv < NL; lv++) begin
            set_in(0, 0, 0, 0, 0, 0, 0); cycle();
            chk("clr_play", 64'(o_state), 64'(ST_PLAY));
            set_in(0, 0, 0, 0, 0, 1, 0); cycle();
            chk("clr_win", 64'(o_state), 64'(ST_WIN));
            set_in(0, 1, 0, 0, 0, 0, 0); cycle();
            if (lv < NL - 1) begin
                chk("clr_next", 64'(o_state), 64'(ST_NEXT));
                chk("clr_req", 64'(o_rand_req), 64'd1);
                chk("clr_level", 64'(o_level), 64'(lv + 1));
                if (lv == 0) chk("clr_mask_l1", 64'(o_fh_active), 64'h1F);
                if (lv == NL - 2) chk("clr_mask_sat", 64'(o_fh_active), 64'h7F);
                set_in(0, 0, 0, 0, 0, 0, 0); cycle();
                chk("clr_req_once", 64'(o_rand_req), 64'd0);
                chk("clr_wait", 64'(o_state), 64'(ST_NEXT));
                set_in(0, 0, 1, 0, 0, 0, 0); cycle();
                chk("clr_brst", 64'(o_state), 64'(ST_BRST));
            end else begin
                chk("clr_clear", 64'(o_state), 64'(ST_CLEAR));
                chk("clr_over", 64'(o_game_over), 64'd1);
            end
        end
        set_in(0, 1, 0, 0, 0, 0, 0); cycle();
        chk("clr_again_ign", 64'(o_state), 64'(ST_CLEAR));
        set_in(1, 0, 0, 0, 0, 0, 0); cycle();
        chk("clr_restart", 64'({o_state, o_lives, o_level}), 64'({4'(ST_NEW), 4'(MAXL), 4'd0}));

        // Asynchronous reset in the middle of a game.
        set_in(0, 0, 1, 1, 0, 0, 0); use_layout(1); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0); cycle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_state", 64'(o_state), 64'(ST_NEW));
        chk("arst_init", 64'({o_bl_pos_initial_x, o_bl_pos_initial_y}), 64'({10'(BIX), 10'(BIY)}));
        chk("arst_wh", 64'({o_wh_pos_x, o_wh_pos_y}), 64'd0);
        check_all();
        @(negedge CLK);
        rst = 1'b0;

        // Random run against the reference model.
        for (int c = 0; c < 3000; c++) begin
            i_new_game    = ($urandom_range(0, 99) < 2);
            i_again       = ($urandom_range(0, 99) < 15);
            i_accel_ready = ($urandom_range(0, 99) < 60);
            i_screenend   = ($urandom_range(0, 99) < 30);
            i_win         = ($urandom_range(0, 99) < 10);
            i_fail        = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 30) i_rand_ready = ~i_rand_ready;
            i_rolling_x = C'($urandom); i_rolling_y = C'($urandom);
            i_fix_x     = C'($urandom); i_fix_y     = C'($urandom);
            if ($urandom_range(0, 3) == 0) rand_layout();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised multi-level game sequencer for the tilt-maze game. It replaces the single-round game state machine in `top` and adds several features: a lives counter, a level progression with a growing number of active fail holes, a per-attempt frame timer and a random-layout request handshake. It sits between `getRandPos`/`myAccelerometerCtrl`/`dropInHoles`/`accelBallMove` and `drawScreenCtrl`, and drives ball/hole coordinates and game status.

## Interface
Parameters:
- `MAX_FAILHOLE_NUM`, 7, number of fail-hole slots N
- `COORD_BIT`, 10, width of one coordinate
- `MAX_LIVES`, 3, lives at new game (1..15)
- `NUM_LEVELS`, 4, levels per game (1..16)
- `BASE_HOLES`, 3, fail holes active at level 0
- `HOLES_PER_LEVEL`, 2, extra fail holes per level
- `TIME_LIMIT_FRAMES`, 1800, frames per attempt (≤4095)
- `BL_INIT_X`, 144, reset ball start x
- `BL_INIT_Y`, 74, reset ball start y

Ports:
- `CLK` in 1: system clock, 100 MHz
- `rst` in 1: asynchronous, active-high reset
- `i_new_game` in 1: one-cycle pulse that starts a new game
- `i_again` in 1: one-cycle pulse that retries or continues
- `i_rand_ready` in 1: `getRandPos` data valid (level)
- `i_rand_list` in 2·COORD_BIT·(N+2): random coordinates
- `i_accel_ready` in 1: accelerometer data valid
- `i_screenend` in 1: one-cycle end-of-frame pulse
- `i_win`, `i_fail` in 1: from `dropInHoles`
- `i_rolling_x/y` in COORD_BIT: `accelBallMove` position
- `i_fix_x/y` in COORD_BIT: `dropInHoles` fall position
- `o_bl_x/y` out COORD_BIT: displayed ball position
- `o_bl_pos_initial_x/y` out COORD_BIT: attempt start position
- `o_wh_pos_x/y` out COORD_BIT: win hole position
- `o_fh_pos_x/y` out COORD_BIT·N: fail hole positions, slot k at bits [COORD_BIT·(k+1)-1 : COORD_BIT·k]
- `o_fh_active` out N: enable mask of active fail holes
- `o_bl_pos_rst` out 1: ball reset strobe to `accelBallMove`
- `o_is_game_playing` out 1: high in PLAYING
- `o_rand_req` out 1: one-cycle request for a new layout
- `o_state` out 4, `o_lives` out 4, `o_level` out 4, `o_time_left` out 12: status
- `o_game_over` out 1: high in OVER or CLEAR

## Operation
- States: NEW=4'h4, BALL_RST=4'h6, AGAIN=4'h5, PLAYING=4'h1, FAIL=4'h2, WIN=4'h3, NEXT=4'h7, OVER=4'h8, CLEAR=4'h9.
- `i_new_game` in any state moves to NEW and sets lives=MAX_LIVES, level=0. It takes priority over every other input.
- NEW: when `i_rand_ready && i_accel_ready`, latch the layout and move to BALL_RST. Otherwise stay in NEW.
- Layout latch, field order in `i_rand_list` LSB first, C=COORD_BIT:
  - fail-hole x: N·C bits
  - win-hole x: C bits
  - ball x: C bits
  - fail-hole y: N·C bits
  - win-hole y: C bits
  - ball y: C bits
- BALL_RST and AGAIN each last one cycle. They assert `o_bl_pos_rst`, reload the timer to TIME_LIMIT_FRAMES, then move to PLAYING.
- PLAYING:
  - `i_again` moves to AGAIN. No life is lost.
  - `i_fail`, or the timer at 0, moves to FAIL and decrements lives.
  - `i_win` moves to WIN.
  - Priority order: `i_again` > fail/timeout > win.
- FAIL: if lives is 0, move to OVER next cycle. Otherwise `i_again` moves to AGAIN.
- WIN:
  - On `i_again` with level < NUM_LEVELS-1: go to NEXT and pulse `o_rand_req` on the transition cycle.
  - On `i_again` at the last level: go to CLEAR.
- NEXT:
  - Increment level on entry.
  - Wait for a rising edge of `i_rand_ready`, detected against a registered previous value.
  - Then latch a new layout and move to BALL_RST. Lives are unchanged.
- OVER and CLEAR are terminal. `i_again` is ignored there; only `i_new_game` leaves them.
- `i_again` is also ignored in NEW, NEXT, BALL_RST and AGAIN.
- `o_fh_active`: lowest M bits set, where M = min(N, BASE_HOLES + level·HOLES_PER_LEVEL). It is registered and updates together with `o_level`.
- Ball mux, combinational from the state register:
  - PLAYING: `i_rolling_*`.
  - FAIL, WIN, OVER, CLEAR: `i_fix_*`.
  - All other states: `o_bl_pos_initial_*`.

## Timing
- Reset values:
  - state NEW, lives MAX_LIVES, level 0, time_left TIME_LIMIT_FRAMES
  - hole coordinates 0, initial ball (BL_INIT_X, BL_INIT_Y)
  - `o_fh_active` = level-0 mask
  - `o_rand_req`, `o_bl_pos_rst`, `o_game_over` all 0
- Every state transition is registered and takes effect one cycle after the qualifying input.
- Layout registers update on the same edge as the state leaves NEW or NEXT.
- Timer:
  - Decrements by 1 on `i_screenend` while in PLAYING, saturating at 0.
  - Holds in every other state.
  - Timeout is seen in PLAYING the cycle after time_left reaches 0.
- Lives decrement is registered on the PLAYING→FAIL edge. The OVER check in FAIL uses the decremented value.
- A `rst` asserted mid-game clears everything asynchronously. There is no partial layout latch.

## Configuration
- `GAME_TIMER_EN` defined: frame timer and timeout-fail behave as above.
- `GAME_TIMER_EN` undefined: no timer logic is built. `o_time_left` is constant TIME_LIMIT_FRAMES and timeouts never occur.

## Test plan
- Reset, then hold `i_rand_ready=1`, `i_accel_ready=1` with list ball x=50, y=60 → NEW→BALL_RST→PLAYING over 2 cycles; `o_bl_pos_initial`=(50,60); `o_bl_pos_rst` high for 1 cycle; `o_fh_active`=7'b0000111.
- In PLAYING, pulse `i_fail` three times, each followed by `i_again` → lives 3→2→1→0; after the third fail, FAIL→OVER; `o_game_over`=1; a further `i_again` is ignored.
- `i_win` and `i_fail` in the same cycle → FAIL, lives decremented.
- WIN at level 0, then `i_again` → `o_rand_req` pulses once; after a rising edge of `i_rand_ready`: level=1, `o_fh_active`=7'b0011111, new layout latched, PLAYING 2 cycles later.
- With `GAME_TIMER_EN` and TIME_LIMIT_FRAMES=3, give 3 `i_screenend` pulses in PLAYING → time_left 3→0, then FAIL; without the macro → stays in PLAYING.
- Win at level NUM_LEVELS-1, then `i_again` → CLEAR; `i_new_game` → NEW with lives=MAX_LIVES, level=0.
